// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock/tick generator.
package clk_div_pkg;

    localparam int W_DEF        = 32;
    localparam int RST_DIV_DEF  = 100000;
    localparam int RST_HIGH_DEF = 50000;

    typedef struct packed {
        logic [W_DEF-1:0] div;
        logic [W_DEF-1:0] high;
    } cfg_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/pending config and output flops.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int RST_DIV  = RST_DIV_DEF,
    parameter int RST_HIGH = RST_HIGH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sync,
    input  logic         wr,
    input  logic [W-1:0] wr_div,
    input  logic [W-1:0] wr_high,
    output logic         clk_out,
    output logic         tick,
    output logic         pend
);

    typedef struct packed {
        logic [W-1:0] div;
        logic [W-1:0] high;
    } ch_cfg_t;

    ch_cfg_t      act, act_n, pnd, pnd_n;
    logic         pend_n;
    logic         run;
    logic [W-1:0] cnt, cnt_n;
    logic         wrap, restart;

    // Wrap test against the registered period only.
    assign wrap    = run && ((cnt + W'(1)) == act.div);
    assign restart = en && (sync || wrap);

    always_comb begin
        act_n  = act;
        pnd_n  = pnd;
        pend_n = pend;
        cnt_n  = '0;
        if (wr && (!en || restart)) begin
            act_n  = '{div: wr_div, high: wr_high};
            pend_n = 1'b0;
        end else if (wr) begin
            pnd_n  = '{div: wr_div, high: wr_high};
            pend_n = 1'b1;
        end else if (restart && pend) begin
            act_n  = pnd;
            pend_n = 1'b0;
        end
        if (en && run && !restart) begin
            cnt_n = cnt + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act     <= '{div: W'(RST_DIV), high: W'(RST_HIGH)};
            pnd     <= '{div: W'(RST_DIV), high: W'(RST_HIGH)};
            pend    <= 1'b0;
            run     <= 1'b0;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            act     <= act_n;
            pnd     <= pnd_n;
            pend    <= pend_n;
            run     <= en;
            cnt     <= cnt_n;
            clk_out <= en && (cnt_n < act_n.high);
            tick    <= en && ((cnt_n + W'(1)) == act_n.div);
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick generator with glitch-free
// ratio updates and a shared phase-align input.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CH       = 4,
    parameter int W        = W_DEF,
    parameter int RST_DIV  = RST_DIV_DEF,
    parameter int RST_HIGH = RST_HIGH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH-1:0]        en,
    input  logic                 sync,
    input  logic                 wr_en,
    input  logic [ch_w(CH)-1:0]  wr_ch,
    input  logic [W-1:0]         wr_div,
    input  logic [W-1:0]         wr_high,
    output logic                 wr_err,
    output logic [CH-1:0]        clk_out,
    output logic [CH-1:0]        tick,
    output logic [CH-1:0]        pend
);

    localparam int CW = ch_w(CH);

    logic ch_ok, div_ok, wr_ok;

    // Extra bit so a power-of-two CH compares without overflow.
    assign ch_ok  = {1'b0, wr_ch} < (CW + 1)'(CH);
    assign div_ok = wr_div >= W'(2);
    assign wr_ok  = wr_en && ch_ok && div_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        clk_div_channel #(
            .W        (W),
            .RST_DIV  (RST_DIV),
            .RST_HIGH (RST_HIGH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync),
            .wr      (wr_ok && (wr_ch == CW'(i))),
            .wr_div  (wr_div),
            .wr_high (wr_high),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock/tick generator; successor to the fixed single-ratio divider.
- Each channel produces a divided enable-clock with a runtime-programmable period and high time, plus a one-cycle tick strobe.
- Ratio changes are glitch-free: they take effect only at a period boundary.
- A shared sync input phase-aligns all channels. Sits between the system clock and slow consumers (display scan, debounce, multiplier step).

Parameters:
- CH, 4, number of independent channels.
- W, 32, width of period/high-time counters and registers.
- RST_DIV, 100000, per-channel period after reset (matches the legacy 50000-toggle divider).
- RST_HIGH, 50000, per-channel high time after reset (50% duty).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  CH  per-channel enable, level.
- sync  in  1  single-cycle pulse; restarts all enabled channels at count 0.
- wr_en  in  1  configuration write strobe.
- wr_ch  in  $clog2(CH) (min 1)  target channel of the write.
- wr_div  in  W  new period P, in clk cycles.
- wr_high  in  W  new high time H, in clk cycles.
- wr_err  out  1  one-cycle pulse: write rejected.
- clk_out  out  CH  divided clock per channel, registered.
- tick  out  CH  one-cycle strobe per channel, registered.
- pend  out  CH  channel holds an unapplied configuration.

Behaviour:
- Reset: every count=0, active P=RST_DIV, H=RST_HIGH, pending cleared. clk_out=0, tick=0, pend=0, wr_err=0.
- Per channel, count c runs 0..P-1 and then wraps to 0. All outputs are registered from the c value taken on the same edge:
  - clk_out = (c < H)
  - tick = (c == P-1)
- Latency from the first enabled edge to the first clk_out change is 1 cycle. The first enabled edge loads c=0.
- H=0 gives clk_out constantly 0. H>=P gives clk_out constantly 1. Neither is an error.
- Disable (en=0): on the next edge c=0, clk_out=0, tick=0. Active and pending configuration are kept.
- Re-enable: the first edge loads c=0.
- Write validity: a write is rejected if wr_div<2 or wr_ch>=CH. On rejection, wr_err=1 for one cycle and no state changes.
- Accepted write, channel disabled: the value goes straight into the active registers; pend stays 0.
- Accepted write, channel enabled: the value goes into the pending registers and pend=1. A second write before the wrap overwrites pending (latest wins).
- Applying pending: at the edge where c wraps (c==P-1 to 0), or on sync, active<=pending and pend<=0. The new P and H govern from c=0 onward, so no truncated or stretched high phase occurs mid-period.
- Simultaneous accepted write and wrap/sync on the same channel: the written value becomes active directly at that edge; pend=0.
- sync: every enabled channel loads c=0 on that edge (counts as a wrap for pending application). tick is not asserted for the interrupted period. Disabled channels are unaffected.
- Simultaneous sync and en rising: the channel starts at c=0. Behaviour is identical either way.
- Reset mid-operation: immediate return to reset values; pending writes are lost.
- Arithmetic: the counter is unsigned W-bit. The comparison c==P-1 uses the registered P, so no combinational subtract from the input appears in the path.

Decomposition:
- Shared package clk_div_pkg:
  - W default
  - RST_DIV and RST_HIGH constants
  - channel-index width function (clog2 with min 1)
  - a config struct (div, high) typedef
- Sub-module clk_div_channel, instantiated CH times, holds:
  - counter
  - active and pending config registers
  - output flops
- Top level holds:
  - write decode and validation
  - wr_err flop
  - sync fan-out

Test Plan:
- Reset default: release rst with en[0]=1 and no writes. clk_out[0] is high for 50000 cycles and low for 50000; tick[0] pulses once per 100000 cycles, in the last cycle.
- Disabled write: with en[1]=0, write ch1 P=5 H=2, then set en[1]=1. clk_out[1] follows the pattern 1,1,0,0,0 repeating; tick[1] is high on every 5th cycle; pend[1] is never 1.
- Mid-period update: ch0 runs P=4 H=2; write P=6 H=3 at c=1. pend[0]=1 until the wrap edge. The current period finishes as 4 cycles, the next is 6 cycles with 3 high, and no glitch occurs.
- Write coincident with wrap: ch0 P=4; write P=8 H=1 on the edge where c=3. The new config applies immediately, pend[0] stays 0, and the next period is 1 high and 7 low.
- Rejection: write wr_div=1, then write wr_ch=CH (with CH non-power-of-2 variant CH=3). wr_err pulses once per write; outputs and pend are unchanged.
- Sync alignment: ch0 P=4 and ch1 P=6 are running out of phase; pulse sync. On the next edge both channels have c=0 and clk_out=1, and no tick is asserted on the sync edge. A disabled ch2 stays 0. An async rst asserted mid-period clears all outputs immediately.
